// File: rtl/cv32e40p_irq_gen_if.sv
// Register access port of cv32e40p_irq_gen: req/gnt request phase, rvalid/rdata response phase.
interface cv32e40p_irq_gen_if;
  logic        req_i;
  logic        we_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/cv32e40p_irq_gen.sv
// Interrupt source block driving the core's irq bus: fast pending bits, MSIP, synchronized external line
// and, when CV32E40P_IRQ_GEN_TIMER_EN is defined, a 64-bit machine timer with compare.
module cv32e40p_irq_gen #(
  parameter int unsigned NUM_FAST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_FAST-1:0] event_i,
  input  logic                ext_irq_i,
  input  logic                tick_i,
  input  logic                irq_ack_i,
  input  logic [4:0]          irq_id_i,
  cv32e40p_irq_gen_if.slave   bus,
  output logic [31:0]         irq_o
);

  logic [NUM_FAST-1:0] pend_q;
  logic [NUM_FAST-1:0] ack_clr;
  logic [NUM_FAST-1:0] w1c_clr;
  logic                msip_q;
  logic                mti_q;
  logic                ext_meta_q;
  logic                ext_sync_q;
  logic                rvalid_q;
  logic [31:0]         rdata_q;
  logic [31:0]         rd_val;
  logic                wr_en;
  logic                rd_en;
  logic [2:0]          word;

  assign wr_en = bus.req_i & bus.we_i;
  assign rd_en = bus.req_i & ~bus.we_i;
  assign word  = bus.addr_i[4:2];

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

`ifdef CV32E40P_IRQ_GEN_TIMER_EN
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        unused_bits;

  assign unused_bits = ^bus.addr_i[1:0];

  // A write to one MTIME half suppresses that cycle's tick entirely, so no carry reaches the other half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mti_q      <= 1'b0;
    end else begin
      mti_q <= (mtime_q >= mtimecmp_q);
      if (wr_en && word == 3'd2) begin
        mtime_q[31:0] <= bus.wdata_i;
      end else if (wr_en && word == 3'd3) begin
        mtime_q[63:32] <= bus.wdata_i;
      end else if (tick_i) begin
        mtime_q <= mtime_q + 64'd1;
      end
      if (wr_en && word == 3'd4) mtimecmp_q[31:0]  <= bus.wdata_i;
      if (wr_en && word == 3'd5) mtimecmp_q[63:32] <= bus.wdata_i;
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{tick_i, bus.addr_i[1:0], bus.wdata_i};
  assign mti_q       = 1'b0;
`endif

  always_comb begin
    ack_clr = '0;
    for (int unsigned k = 0; k < NUM_FAST; k++) begin
      if (irq_ack_i && irq_id_i == 5'(16 + k)) ack_clr[k] = 1'b1;
    end
  end

  assign w1c_clr = (wr_en && word == 3'd0) ? bus.wdata_i[16 +: NUM_FAST] : '0;

  always_comb begin
    irq_o                  = '0;
    irq_o[3]               = msip_q;
    irq_o[7]               = mti_q;
    irq_o[11]              = ext_sync_q;
    irq_o[16 +: NUM_FAST]  = pend_q;
  end

  always_comb begin
    rd_val = '0;
    case (word)
      3'd0: rd_val = irq_o;
      3'd1: rd_val = {31'b0, msip_q};
`ifdef CV32E40P_IRQ_GEN_TIMER_EN
      3'd2: rd_val = mtime_q[31:0];
      3'd3: rd_val = mtime_q[63:32];
      3'd4: rd_val = mtimecmp_q[31:0];
      3'd5: rd_val = mtimecmp_q[63:32];
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      msip_q     <= 1'b0;
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // Event set is applied after both clear sources so a coincident event keeps the bit.
      pend_q     <= (pend_q & ~(ack_clr | w1c_clr)) | event_i;
      ext_meta_q <= ext_irq_i;
      ext_sync_q <= ext_meta_q;
      rvalid_q   <= bus.req_i;
      rdata_q    <= rd_en ? rd_val : '0;
      if (wr_en && word == 3'd1) msip_q <= bus.wdata_i[0];
    end
  end

endmodule
